hazard_ctrl: RTL

Parametrised pipeline control unit: the successor to the fixed 6-bit stall controller. It merges per-stage stall requests into back-pressure, inserts bubbles, and generates branch-redirect flushes, including flushes deferred across a front-end stall. It adds a register scoreboard for RAW and WAW hazard detection, so the decode stage no longer needs a hardwired zero stall request. It sits beside the IF/ID/EX/MEM/WB pipeline registers and drives their stall, bubble and flush inputs.

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_ctrl_scoreboard.sv | 76 +++++++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: pipeline stage indices and default
// geometry shared by hazard_ctrl and reg_scoreboard.
package hazard_ctrl_pkg;

  localparam int NSTAGE_DEF = 5;
  localparam int NREG_DEF   = 32;
  localparam int CNT_W_DEF  = 2;
  localparam int PERF_W_DEF = 32;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// reg_scoreboard: pending-writer counters per register,
// retire bypass, RAW/WAW compare and sticky retire error.
// in : clk, rst, issue srcs/dst, alloc_i, retire_i/rd
// out: hit_o (RAW|WAW before gating), sb_err_o
import hazard_ctrl_pkg::*;

module reg_scoreboard #(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    re1_i,
  input  logic [$clog2(NREG)-1:0] rs1_i,
  input  logic                    re2_i,
  input  logic [$clog2(NREG)-1:0] rs2_i,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] rd_i,
  input  logic                    alloc_i,
  input  logic                    retire_i,
  input  logic [$clog2(NREG)-1:0] retire_rd_i,
  output logic                    hit_o,
  output logic                    sb_err_o
);

  localparam int AW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] eff   [NREG];
  logic             err_q;
  logic             raw;
  logic             waw;

  // Retiring writer is already visible through the
  // write-through regfile, so discount it this cycle.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      eff[r] = cnt_q[r];
      if (retire_i && retire_rd_i == AW'(r)
          && cnt_q[r] != '0)
        eff[r] = cnt_q[r] - 1'b1;
    end
  end

  assign raw = (re1_i && eff[rs1_i] != '0)
             | (re2_i && eff[rs2_i] != '0);
  assign waw = we_i && rd_i != '0
             && eff[rd_i] == CMAX;
  assign hit_o    = raw | waw;
  assign sb_err_o = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (alloc_i && rd_i == AW'(r)) begin
          if (!(retire_i && retire_rd_i == AW'(r)
                && cnt_q[r] != '0))
            cnt_q[r] <= cnt_q[r] + 1'b1;
        end else if (retire_i
                     && retire_rd_i == AW'(r)
                     && cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
      if (retire_i && retire_rd_i != '0
          && cnt_q[retire_rd_i] == '0)
        err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush generation, deferred
// redirect flush, scoreboard hazard and hazard counter.
// in : clk, rst, stall_req_i, issue_*, retire_*, redirect_i
// out: stall_o, bubble_o, flush_o, hazard_o, sb_err_o,
//      hazard_cnt_o
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int NSTAGE      = NSTAGE_DEF,
  parameter int NREG        = NREG_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int ISSUE_STAGE = STG_ID,
  parameter int FLUSH_STAGE = STG_EX,
  parameter int PERF_W      = PERF_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSTAGE-1:0]       stall_req_i,
  input  logic                    issue_valid_i,
  input  logic                    issue_we_i,
  input  logic [$clog2(NREG)-1:0] issue_rd_i,
  input  logic                    issue_re1_i,
  input  logic [$clog2(NREG)-1:0] issue_rs1_i,
  input  logic                    issue_re2_i,
  input  logic [$clog2(NREG)-1:0] issue_rs2_i,
  input  logic                    retire_i,
  input  logic [$clog2(NREG)-1:0] retire_rd_i,
  input  logic                    redirect_i,
  output logic [NSTAGE-1:0]       stall_o,
  output logic [NSTAGE-1:0]       bubble_o,
  output logic [NSTAGE-1:0]       flush_o,
  output logic                    hazard_o,
  output logic                    sb_err_o,
  output logic [PERF_W-1:0]       hazard_cnt_o
);

  logic              sb_hit;
  logic              hz;
  logic              alloc;
  logic              acc;
  logic              pend_q;
  logic              pend_d;
  logic [NSTAGE-1:0] req_st;
  logic [NSTAGE-1:0] st_raw;
  logic [NSTAGE-1:0] bb_raw;
  logic [NSTAGE-1:0] fl_now;
  logic [PERF_W-1:0] hcnt_q;

  reg_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .re1_i       (issue_re1_i),
    .rs1_i       (issue_rs1_i),
    .re2_i       (issue_re2_i),
    .rs2_i       (issue_rs2_i),
    .we_i        (issue_we_i),
    .rd_i        (issue_rd_i),
    .alloc_i     (alloc),
    .retire_i    (retire_i),
    .retire_rd_i (retire_rd_i),
    .hit_o       (sb_hit),
    .sb_err_o    (sb_err_o)
  );

  assign hz = rst & issue_valid_i & ~redirect_i & sb_hit;

  // A stall anywhere downstream holds every stage above it.
  always_comb begin
    acc    = 1'b0;
    req_st = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      acc       = acc | stall_req_i[k];
      req_st[k] = acc;
    end
  end

  // Bubbles come from the pre-flush stall view so a stage
  // being flushed never lets wrong-path work slide down.
  always_comb begin
    st_raw = '0;
    bb_raw = '0;
    fl_now = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      st_raw[k] = req_st[k] | (hz & (k <= ISSUE_STAGE));
      fl_now[k] = redirect_i & (k < FLUSH_STAGE);
    end
    for (int k = 1; k < NSTAGE; k++)
      bb_raw[k] = st_raw[k-1] & ~st_raw[k];
    fl_now[0] = fl_now[0] | (pend_q & ~st_raw[0]);
  end

  assign stall_o  = rst ? (st_raw & ~fl_now) : '0;
  assign bubble_o = rst ? (bb_raw & ~fl_now) : '0;
  assign flush_o  = rst ? fl_now : '1;
  assign hazard_o = hz;

  assign alloc = issue_valid_i & issue_we_i
               & ~st_raw[ISSUE_STAGE] & ~redirect_i;

  // Held redirect waits for fetch to move, then kills the
  // wrong-path fetch; a redirect that same cycle re-arms it.
  assign pend_d = (redirect_i & st_raw[0])
                | (pend_q & st_raw[0])
                | (pend_q & redirect_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      hcnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      hcnt_q <= hcnt_q + PERF_W'(hz);
    end
  end

  assign hazard_cnt_o = hcnt_q;

endmodule
